// File: rtl/alu_input_pkg.sv
// alu_input_pkg: shared types and constants for the decimal entry front end
//   N_BTN_DEF  default number of digit pushbuttons
//   KEY_W      width of a digit code
//   key_code_t digit code type
//   kp_state_t single-key lockout FSM states
package alu_input_pkg;
    localparam int N_BTN_DEF = 10;
    localparam int KEY_W = 4;
    typedef logic [KEY_W-1:0] key_code_t;
    typedef enum logic {KP_IDLE, KP_HELD} kp_state_t;
endpackage

// File: rtl/pb_debounce_encoder_if.sv
// pb_debounce_encoder_if: raw pushbutton levels in, clean key events out
//   pb          raw asynchronous button levels, active-high
//   key_valid   one-cycle pulse per accepted press
//   key_code    digit of the last accepted press
//   key_held    level, any debounced button down
//   key_reject  one-cycle pulse per press ignored by lockout
//   master: the encoder; slave: the button source / digit consumer
interface pb_debounce_encoder_if
    import alu_input_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0] pb;
    logic             key_valid;
    key_code_t        key_code;
    logic             key_held;
    logic             key_reject;

    modport master (input pb, output key_valid, key_code, key_held, key_reject);
    modport slave (output pb, input key_valid, key_code, key_held, key_reject);
endinterface

// File: rtl/pb_debounce_bit.sv
// pb_debounce_bit: synchroniser plus counter debounce for one pushbutton
//   clk, rst_n  clock, asynchronous active-low reset
//   pb          raw asynchronous level
//   stable      debounced level
module pb_debounce_bit #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic stable
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the current stable level restarts the count,
    // so only DB_CYCLES consecutive differing samples flip stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
            if (s2 == stable)
                cnt <= '0;
            else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pb_debounce_encoder.sv
// pb_debounce_encoder: debounced digit pushbuttons to single-cycle key events
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         master side of pb_debounce_encoder_if (pb in, key_* out)
module pb_debounce_encoder
    import alu_input_pkg::*;
#(
    parameter int N_BTN     = N_BTN_DEF,
    parameter int DB_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pb_debounce_encoder_if.master   bus
);
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] rise;
    key_code_t        low_idx;
    kp_state_t        state;

    for (genvar i = 0; i < N_BTN; i++) begin : g_bit
        pb_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .pb     (bus.pb[i]),
            .stable (stable[i])
        );
    end

    assign rise = stable & ~stable_d;

    // Scan downwards so the lowest rising index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--)
            if (rise[i])
                low_idx = key_code_t'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= KP_IDLE;
            stable_d       <= '0;
            bus.key_valid  <= 1'b0;
            bus.key_code   <= '0;
            bus.key_held   <= 1'b0;
            bus.key_reject <= 1'b0;
        end else begin
            stable_d       <= stable;
            bus.key_held   <= |stable;
            bus.key_valid  <= 1'b0;
            bus.key_reject <= 1'b0;
            if (state == KP_IDLE) begin
                // A rise alongside an already-down button is not a clean
                // single press; lock out without emitting a key.
                if (|rise) begin
                    if (!(|(stable & ~rise))) begin
                        bus.key_valid <= 1'b1;
                        bus.key_code  <= low_idx;
                    end
                    state <= KP_HELD;
                end
            end else begin
                bus.key_reject <= |rise;
                if (!(|stable))
                    state <= KP_IDLE;
            end
        end
    end
endmodule
